// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the prioritised interrupt controller.
//   irq_state_t      : request FSM states (IDLE, ASSERT)
//   CTRL_ADDR        : word address of the CTRL register (mask / vector base)
//   STATUS_ADDR      : word address of the STATUS register (pending / in-service)
//   SPURIOUS_OFFSET  : vector offset returned for an inta with no request
// ---------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } irq_state_t;

  localparam logic       CTRL_ADDR       = 1'b0;
  localparam logic       STATUS_ADDR     = 1'b1;
  localparam logic [7:0] SPURIOUS_OFFSET = 8'd7;

endpackage

// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
// Finds the lowest set bit of a request vector (index 0 = highest priority).
// Ports:
//   i_req    in   N   request bits
//   o_valid  out  1   at least one request bit is set
//   o_index  out  3   index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [2:0]   o_index
);

  // Scan from the lowest priority upward so the lowest index is written last.
  always_comb begin
    o_valid = 1'b0;
    o_index = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      o_index = i_req[i] ? 3'(i) : o_index;
      o_valid = o_valid | i_req[i];
    end
  end

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Prioritised interrupt controller between bus peripherals and the CPU core.
// Latches rising edges on the irq lines, applies a mask, raises intr toward
// the CPU, returns a vector on inta and tracks in-service levels until the
// software writes an EOI. Exposes a two-word register block on data_m.
// Ports:
//   clk              in   1         system clock
//   reset            in   1         asynchronous, active-high reset
//   cs               in   1         chip select for this register block
//   data_m_addr      in   [1:1]     0 = CTRL, 1 = STATUS
//   data_m_data_in   in   16        write data
//   data_m_data_out  out  16        registered read data, 0 when not reading
//   data_m_bytesel   in   2         byte enables ([0] = 7:0, [1] = 15:8)
//   data_m_wr_en     in   1         1 = write, 0 = read
//   data_m_access    in   1         bus access strobe
//   data_m_ack       out  1         access acknowledge, one cycle after access
//   irq_in           in   NUM_IRQS  edge-sensitive peripheral irq lines
//   intr             out  1         interrupt request to the CPU
//   inta             in   1         one-cycle interrupt-acknowledge pulse
//   irq_vector       out  8         vector, valid from the cycle after inta
// ---------------------------------------------------------------------------
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic [1:1]          data_m_addr,
  input  logic [15:0]         data_m_data_in,
  output logic [15:0]         data_m_data_out,
  input  logic [1:0]          data_m_bytesel,
  input  logic                data_m_wr_en,
  input  logic                data_m_access,
  output logic                data_m_ack,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                intr,
  input  logic                inta,
  output logic [7:0]          irq_vector
);

  logic [7:0]          r_mask;
  logic [7:0]          r_vector_base;
  logic [NUM_IRQS-1:0] r_pending;
  logic [NUM_IRQS-1:0] r_in_service;
  logic [NUM_IRQS-1:0] r_irq_prev;
  irq_state_t          r_state;
  logic [2:0]          r_idx;

  logic                w_bus_rd;
  logic                w_ctrl_wr;
  logic                w_status_wr;
  logic [7:0]          w_eoi;
  logic [NUM_IRQS-1:0] w_edge;
  logic                w_inta_take;
  logic [NUM_IRQS-1:0] w_take;
  logic [NUM_IRQS-1:0] w_cand_req;
  logic                w_cand_valid;
  logic [2:0]          w_cand_idx;
  logic                w_is_valid;
  logic [2:0]          w_is_idx;
  logic                w_cand_ok;
  logic [7:0]          w_pending8;
  logic [7:0]          w_in_service8;

  assign w_bus_rd    = cs & data_m_access & ~data_m_wr_en;
  assign w_ctrl_wr   = cs & data_m_access & data_m_wr_en & (data_m_addr == CTRL_ADDR);
  assign w_status_wr = cs & data_m_access & data_m_wr_en & (data_m_addr == STATUS_ADDR);
  assign w_eoi       = (w_status_wr & data_m_bytesel[0]) ? data_m_data_in[7:0] : 8'h00;
  assign w_edge      = irq_in & ~r_irq_prev;
  assign w_inta_take = (r_state == ASSERT) & inta;
  assign w_cand_req  = r_pending & ~r_mask[NUM_IRQS-1:0];

  // A candidate only counts if it outranks every level already in service.
  assign w_cand_ok = w_cand_valid & (~w_is_valid | (w_cand_idx < w_is_idx));

  // One-hot of the request being acknowledged this cycle.
  always_comb begin
    w_take = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      w_take[i] = w_inta_take & (r_idx == 3'(i));
    end
  end

  // Zero-extend the per-line state to the 8-bit STATUS fields.
  always_comb begin
    w_pending8                    = 8'h00;
    w_in_service8                 = 8'h00;
    w_pending8[NUM_IRQS-1:0]      = r_pending;
    w_in_service8[NUM_IRQS-1:0]   = r_in_service;
  end

  irq_priority_encoder #(.N(NUM_IRQS)) u_cand_enc (
    .i_req   (w_cand_req),
    .o_valid (w_cand_valid),
    .o_index (w_cand_idx)
  );

  irq_priority_encoder #(.N(NUM_IRQS)) u_is_enc (
    .i_req   (r_in_service),
    .o_valid (w_is_valid),
    .o_index (w_is_idx)
  );

  // Bus side: ack, registered read data and CTRL byte writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_m_ack      <= 1'b0;
      data_m_data_out <= 16'h0000;
      r_mask          <= 8'hFF;
      r_vector_base   <= 8'h00;
    end else begin
      data_m_ack <= cs & data_m_access;
      if (w_bus_rd) begin
        data_m_data_out <= (data_m_addr == STATUS_ADDR) ? {w_in_service8, w_pending8}
                                                        : {r_vector_base, r_mask};
      end else begin
        data_m_data_out <= 16'h0000;
      end
      if (w_ctrl_wr & data_m_bytesel[0]) begin
        r_mask <= data_m_data_in[7:0];
      end
      if (w_ctrl_wr & data_m_bytesel[1]) begin
        r_vector_base <= data_m_data_in[15:8];
      end
    end
  end

  // Edge capture plus pending / in-service bookkeeping; sets beat clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev   <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
    end else begin
      r_irq_prev   <= irq_in;
      r_pending    <= (r_pending & ~w_take) | w_edge;
      r_in_service <= (r_in_service & ~w_eoi[NUM_IRQS-1:0]) | w_take;
    end
  end

  // Request FSM: raises intr, tracks the offered index, produces the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      intr       <= 1'b0;
      irq_vector <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (inta) begin
            irq_vector <= r_vector_base + SPURIOUS_OFFSET;
          end
          if (w_cand_ok) begin
            r_state <= ASSERT;
            r_idx   <= w_cand_idx;
            intr    <= 1'b1;
          end
        end
        ASSERT: begin
          if (inta) begin
            irq_vector <= r_vector_base + {5'b00000, r_idx};
            intr       <= 1'b0;
            r_state    <= IDLE;
          end else if (w_cand_ok && (w_cand_idx <= r_idx)) begin
            // Same request still valid, or a higher-priority one overtook it.
            r_idx <= w_cand_idx;
          end else begin
            // Request withdrawn (masked or outranked by in-service): no vector.
            intr    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          intr    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        addr_b;
  logic [15:0] din;
  logic [15:0] dout;
  logic [1:0]  bsel;
  logic        wr_en;
  logic        access;
  logic        ack;
  logic [7:0]  irq_in;
  logic        intr;
  logic        inta;
  logic [7:0]  irq_vector;

  int total = 0;
  int bad   = 0;

  // Reference state, kept as plain bit sets and numbers.
  logic [7:0]  m_pend, m_insvc, m_prev, m_mask, m_base, m_vec;
  logic        m_intr, m_ack;
  logic [2:0]  m_idx;
  logic [15:0] m_dout;

  irq_controller #(.NUM_IRQS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_addr     (addr_b),
    .data_m_data_in  (din),
    .data_m_data_out (dout),
    .data_m_bytesel  (bsel),
    .data_m_wr_en    (wr_en),
    .data_m_access   (access),
    .data_m_ack      (ack),
    .irq_in          (irq_in),
    .intr            (intr),
    .inta            (inta),
    .irq_vector      (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 8;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_insvc = 8'h00; m_prev = 8'h00; m_mask = 8'hFF;
    m_base = 8'h00; m_vec = 8'h00; m_intr = 1'b0; m_idx = 3'd0;
    m_ack = 1'b0; m_dout = 16'h0000;
  endtask

  // Advance the reference by one clock using the inputs currently driven.
  task automatic model_step();
    int c;
    int s;
    bit ok;
    logic [7:0] take;
    logic [7:0] eoi;
    take = 8'h00;
    eoi  = 8'h00;
    c  = lowest(m_pend & ~m_mask);
    s  = lowest(m_insvc);
    ok = (c < 8) && (c < s);
    if (m_intr && inta) begin
      m_vec = m_base + {5'b00000, m_idx};
      take[m_idx] = 1'b1;
      m_intr = 1'b0;
    end else if (m_intr) begin
      if (ok && (c <= int'(m_idx))) m_idx = c[2:0];
      else m_intr = 1'b0;
    end else begin
      if (inta) m_vec = m_base + 8'd7;
      if (ok) begin
        m_intr = 1'b1;
        m_idx  = c[2:0];
      end
    end
    m_ack  = cs & access;
    m_dout = 16'h0000;
    if (cs && access && !wr_en) m_dout = addr_b ? {m_insvc, m_pend} : {m_base, m_mask};
    if (cs && access && wr_en && !addr_b) begin
      if (bsel[0]) m_mask = din[7:0];
      if (bsel[1]) m_base = din[15:8];
    end
    if (cs && access && wr_en && addr_b && bsel[0]) eoi = din[7:0];
    m_pend  = (m_pend & ~take) | (irq_in & ~m_prev);
    m_insvc = (m_insvc & ~eoi) | take;
    m_prev  = irq_in;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("intr", {15'b0, intr}, {15'b0, m_intr});
    chk("vector", {8'h00, irq_vector}, {8'h00, m_vec});
    chk("ack", {15'b0, ack}, {15'b0, m_ack});
    chk("rdata", dout, m_dout);
  endtask

  task automatic bus_clear();
    cs = 1'b0; access = 1'b0; wr_en = 1'b0; addr_b = 1'b0; din = 16'h0000; bsel = 2'b00;
  endtask

  task automatic bus_wr(input logic a, input logic [15:0] d, input logic [1:0] be);
    cs = 1'b1; access = 1'b1; wr_en = 1'b1; addr_b = a; din = d; bsel = be;
    cycle();
    bus_clear();
  endtask

  task automatic bus_rd(input logic a, output logic [15:0] q);
    cs = 1'b1; access = 1'b1; wr_en = 1'b0; addr_b = a; bsel = 2'b11;
    cycle();
    q = dout;
    bus_clear();
  endtask

  task automatic pulse_irq(input logic [7:0] lines);
    irq_in = lines;
    cycle();
    irq_in = 8'h00;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    cycle();
    inta = 1'b0;
  endtask

  initial begin
    logic [15:0] q;
    int r;
    reset = 1'b1; inta = 1'b0; irq_in = 8'h00;
    bus_clear();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_intr", {15'b0, intr}, 16'h0000);
    chk("rst_vec", {8'h00, irq_vector}, 16'h0000);
    chk("rst_ack", {15'b0, ack}, 16'h0000);
    chk("rst_rdata", dout, 16'h0000);
    bus_rd(1'b0, q);
    chk("rst_ctrl", q, 16'h00FF);

    // 1: base 0x20, only irq0 unmasked; intr two cycles after the edge
    bus_wr(1'b0, 16'h20FE, 2'b11);
    irq_in = 8'h01;
    cycle();
    chk("t1_n1", {15'b0, intr}, 16'h0000);
    irq_in = 8'h00;
    cycle();
    chk("t1_n2", {15'b0, intr}, 16'h0001);
    pulse_inta();
    chk("t1_vec", {8'h00, irq_vector}, 16'h0020);
    bus_rd(1'b1, q);
    chk("t1_status", q, 16'h0100);
    bus_wr(1'b1, 16'h0001, 2'b01);

    // 2: simultaneous edges on 3 and 1
    bus_wr(1'b0, 16'h2000, 2'b11);
    pulse_irq(8'h0A);
    cycle();
    chk("t2_intr", {15'b0, intr}, 16'h0001);
    pulse_inta();
    chk("t2_vec1", {8'h00, irq_vector}, 16'h0021);
    repeat (3) cycle();
    chk("t2_blocked", {15'b0, intr}, 16'h0000);
    bus_wr(1'b1, 16'h0002, 2'b01);
    cycle();
    chk("t2_intr2", {15'b0, intr}, 16'h0001);
    pulse_inta();
    chk("t2_vec3", {8'h00, irq_vector}, 16'h0023);
    bus_wr(1'b1, 16'h0008, 2'b01);

    // 3: irq4 in service blocks irq6 until EOI
    pulse_irq(8'h10);
    cycle();
    pulse_inta();
    chk("t3_vec4", {8'h00, irq_vector}, 16'h0024);
    pulse_irq(8'h40);
    repeat (3) cycle();
    chk("t3_blocked", {15'b0, intr}, 16'h0000);
    bus_wr(1'b1, 16'h0010, 2'b01);
    cycle();
    chk("t3_intr", {15'b0, intr}, 16'h0001);
    pulse_inta();
    chk("t3_vec6", {8'h00, irq_vector}, 16'h0026);
    bus_wr(1'b1, 16'h0040, 2'b01);

    // 4: masking a raised request withdraws intr, pending is kept
    pulse_irq(8'h04);
    cycle();
    chk("t4_intr", {15'b0, intr}, 16'h0001);
    bus_wr(1'b0, 16'h0004, 2'b01);
    cycle();
    chk("t4_masked", {15'b0, intr}, 16'h0000);
    bus_rd(1'b1, q);
    chk("t4_status", q, 16'h0004);
    bus_wr(1'b0, 16'h0000, 2'b01);
    cycle();
    chk("t4_unmask", {15'b0, intr}, 16'h0001);
    pulse_inta();
    chk("t4_vec", {8'h00, irq_vector}, 16'h0022);
    bus_wr(1'b1, 16'h0004, 2'b01);

    // 5: spurious inta
    bus_wr(1'b0, 16'h4000, 2'b11);
    pulse_inta();
    chk("t5_spur", {8'h00, irq_vector}, 16'h0047);
    bus_rd(1'b1, q);
    chk("t5_status", q, 16'h0000);

    // 6: high-byte-only write to CTRL, ack lasts one cycle
    bus_wr(1'b0, 16'h5511, 2'b10);
    chk("t6_ack", {15'b0, ack}, 16'h0001);
    cycle();
    chk("t6_ack_off", {15'b0, ack}, 16'h0000);
    bus_rd(1'b0, q);
    chk("t6_ctrl", q, 16'h5500);

    // 7: new edge during its own inta, and EOI colliding with inta
    pulse_irq(8'h20);
    cycle();
    inta = 1'b1; irq_in = 8'h20;
    cycle();
    inta = 1'b0; irq_in = 8'h00;
    chk("t7_vec", {8'h00, irq_vector}, 16'h005A);
    bus_rd(1'b1, q);
    chk("t7_setwins_p", q, 16'h2020);
    bus_wr(1'b1, 16'h0020, 2'b01);
    cycle();
    chk("t7_intr", {15'b0, intr}, 16'h0001);
    inta = 1'b1;
    bus_wr(1'b1, 16'h0020, 2'b01);
    inta = 1'b0;
    bus_rd(1'b1, q);
    chk("t7_setwins_is", q, 16'h2000);
    bus_wr(1'b1, 16'h0020, 2'b01);

    // 8: reset while intr is raised drops it without a clock edge
    pulse_irq(8'h01);
    cycle();
    chk("t8_intr", {15'b0, intr}, 16'h0001);
    #3;
    reset = 1'b1;
    #1;
    chk("t8_async", {15'b0, intr}, 16'h0000);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Random traffic against the reference
    bus_wr(1'b0, 16'h3000, 2'b11);
    for (int n = 0; n < 1500; n++) begin
      irq_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
      inta   = (m_intr && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 40) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0: begin cs = 1'b1; access = 1'b1; wr_en = 1'b0; addr_b = 1'b1; end
        1: begin cs = 1'b1; access = 1'b1; wr_en = 1'b0; addr_b = 1'b0; end
        2, 3: begin
          cs = 1'b1; access = 1'b1; wr_en = 1'b1; addr_b = 1'b1;
          din = {8'($urandom), m_insvc & 8'($urandom)}; bsel = 2'($urandom_range(0, 3));
        end
        4: begin
          cs = 1'b1; access = 1'b1; wr_en = 1'b1; addr_b = 1'b0;
          din = {8'($urandom), 8'($urandom) & 8'($urandom)}; bsel = 2'($urandom_range(0, 3));
        end
        5: begin cs = 1'b1; access = 1'b0; wr_en = 1'($urandom); addr_b = 1'($urandom); end
        6: begin cs = 1'b0; access = 1'b1; wr_en = 1'b0; addr_b = 1'b1; end
        default: bus_clear();
      endcase
      cycle();
      bus_clear();
      inta = 1'b0;
    end
    irq_in = 8'h00;
    bus_rd(1'b1, q);
    chk("final_status", q, {m_insvc, m_pend});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
